// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed seven-segment scan controller: DIGITS common-anode digits, hex font, dp, blanking, 16-level PWM, dead time.
// Latency: all outputs registered, one cycle behind the scan counters; inputs captured once per frame at digit 0 / slot 0.
// Backpressure: none; free-running scan, input changes mid-frame are held off until the next frame capture.
// Optional feature: define SEG7_LZS_EN for leading-zero suppression.
module seg7_scan_ctrl #(
    parameter int DIGITS    = 4,
    parameter int SLOT_CYC  = 125000,
    parameter int BLANK_CYC = 500
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic [4*DIGITS-1:0]   data_i,
    input  logic [DIGITS-1:0]     dp_i,
    input  logic [DIGITS-1:0]     blank_i,
    input  logic [3:0]            bright_i,
    output logic [6:0]            seg_o,
    output logic                  dp_o,
    output logic [DIGITS-1:0]     an_o,
    output logic                  frame_o
);

    localparam int SLOT_W = (SLOT_CYC > 1) ? $clog2(SLOT_CYC) : 1;
    localparam int DIG_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOT_CYC - 1);
    localparam logic [SLOT_W-1:0] ACT_START = SLOT_W'(BLANK_CYC);
    localparam logic [DIG_W-1:0]  DIG_LAST  = DIG_W'(DIGITS - 1);

    logic [SLOT_W-1:0]   slot_cnt;
    logic [DIG_W-1:0]    dig_idx;
    logic [3:0]          pwm_cnt;

    logic [4*DIGITS-1:0] sh_data;
    logic [DIGITS-1:0]   sh_dp;
    logic [DIGITS-1:0]   sh_blank;
    logic [3:0]          sh_bright;

    logic                capture;
    logic [4*DIGITS-1:0] cur_data;
    logic [DIGITS-1:0]   cur_dp;
    logic [DIGITS-1:0]   cur_blank;
    logic [3:0]          cur_bright;
    logic [DIGITS-1:0]   lz_mask;
    logic [DIGITS-1:0]   seg_dark;
    logic [DIGITS-1:0]   an_dark;

    logic [3:0]          sel_nib;
    logic                sel_dp;
    logic                sel_seg_dark;
    logic                sel_an_dark;
    logic [DIGITS-1:0]   an_nxt;

    function automatic logic [6:0] hex_font(input logic [3:0] nib);
        logic [6:0] f;
        case (nib)
            4'h0: f = 7'h40;
            4'h1: f = 7'h79;
            4'h2: f = 7'h24;
            4'h3: f = 7'h30;
            4'h4: f = 7'h19;
            4'h5: f = 7'h12;
            4'h6: f = 7'h02;
            4'h7: f = 7'h78;
            4'h8: f = 7'h00;
            4'h9: f = 7'h10;
            4'hA: f = 7'h08;
            4'hB: f = 7'h03;
            4'hC: f = 7'h46;
            4'hD: f = 7'h21;
            4'hE: f = 7'h06;
            default: f = 7'h0E;
        endcase
        return f;
    endfunction

    // On the capture cycle the live inputs are used so the first slot of a frame already shows the new values.
    assign capture    = (dig_idx == '0) && (slot_cnt == '0);
    assign cur_data   = capture ? data_i   : sh_data;
    assign cur_dp     = capture ? dp_i     : sh_dp;
    assign cur_blank  = capture ? blank_i  : sh_blank;
    assign cur_bright = capture ? bright_i : sh_bright;

`ifdef SEG7_LZS_EN
    // A digit is suppressed when it and every digit above it hold zero; digit 0 always shows.
    always_comb begin
        logic upper_zero;
        lz_mask    = '0;
        upper_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            upper_zero = upper_zero & (cur_data[4*i +: 4] == 4'h0);
            lz_mask[i] = upper_zero;
        end
    end
`else
    assign lz_mask = '0;
`endif

    // Suppressed digits keep their anode only when a decimal point must still be shown.
    assign seg_dark = cur_blank | lz_mask;
    assign an_dark  = cur_blank | (lz_mask & ~cur_dp);

    // Pick the attributes of the digit currently being scanned.
    always_comb begin
        sel_nib      = 4'h0;
        sel_dp       = 1'b0;
        sel_seg_dark = 1'b1;
        sel_an_dark  = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (dig_idx == DIG_W'(i)) begin
                sel_nib      = cur_data[4*i +: 4];
                sel_dp       = cur_dp[i];
                sel_seg_dark = seg_dark[i];
                sel_an_dark  = an_dark[i];
            end
        end
    end

    // Anode for the scanned digit goes low only in the active window while PWM is within the brightness level.
    always_comb begin
        an_nxt = '1;
        if ((slot_cnt >= ACT_START) && (pwm_cnt <= cur_bright) && !sel_an_dark) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (dig_idx == DIG_W'(i)) begin
                    an_nxt[i] = 1'b0;
                end
            end
        end
    end

    // Scan counters: slot cycle, digit index, free-running PWM phase.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            slot_cnt <= '0;
            dig_idx  <= '0;
            pwm_cnt  <= 4'h0;
        end else begin
            pwm_cnt <= pwm_cnt + 4'h1;
            if (slot_cnt == SLOT_LAST) begin
                slot_cnt <= '0;
                dig_idx  <= (dig_idx == DIG_LAST) ? '0 : dig_idx + 1'b1;
            end else begin
                slot_cnt <= slot_cnt + 1'b1;
            end
        end
    end

    // Frame-synchronous shadow capture keeps a frame tear-free.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sh_data   <= '0;
            sh_dp     <= '0;
            sh_blank  <= '0;
            sh_bright <= 4'h0;
        end else if (capture) begin
            sh_data   <= data_i;
            sh_dp     <= dp_i;
            sh_blank  <= blank_i;
            sh_bright <= bright_i;
        end
    end

    // Registered pin drivers; segments and dp only change at slot start, inside the dead time.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            seg_o   <= 7'h7F;
            dp_o    <= 1'b1;
            an_o    <= '1;
            frame_o <= 1'b0;
        end else begin
            an_o    <= an_nxt;
            frame_o <= capture;
            if (slot_cnt == '0) begin
                seg_o <= sel_seg_dark ? 7'h7F : hex_font(sel_nib);
                dp_o  <= (sel_dp && !sel_an_dark) ? 1'b0 : 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: directed scenarios plus random input changes, checked every cycle against a frame/slot timeline model.
// Model: output after edge k reflects frame position k mod 80 and PWM phase k mod 16; shadows are inputs seen at frame-start edges.
// Honours SEG7_LZS_EN in the model when the macro is defined for the build.
module tb_seg7_scan_ctrl;

    localparam int DIGITS = 4;
    localparam int SLOT   = 20;
    localparam int BLANK  = 4;
    localparam int FRAME  = DIGITS * SLOT;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] data = 16'h0;
    logic [3:0]  dp = 4'h0;
    logic [3:0]  blank = 4'h0;
    logic [3:0]  bright = 4'h0;
    logic [6:0]  seg_o;
    logic        dp_o;
    logic [3:0]  an_o;
    logic        frame_o;

    int tests = 0;
    int fails = 0;
    int k = 0;
    int low_cnt = 0;
    int sh_nib[DIGITS];
    logic [3:0] sh_dp = 4'h0;
    logic [3:0] sh_blank = 4'h0;
    int sh_bright = 0;

    logic [6:0] font[16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    seg7_scan_ctrl #(.DIGITS(DIGITS), .SLOT_CYC(SLOT), .BLANK_CYC(BLANK)) dut (
        .clk_i    (clk),
        .rst_n_i  (rst_n),
        .data_i   (data),
        .dp_i     (dp),
        .blank_i  (blank),
        .bright_i (bright),
        .seg_o    (seg_o),
        .dp_o     (dp_o),
        .an_o     (an_o),
        .frame_o  (frame_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h (k=%0d)", tag, obs, exp, k);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_seg"},   {25'd0, seg_o},   32'h7F);
        check({tag, "_dp"},    {31'd0, dp_o},    32'h1);
        check({tag, "_an"},    {28'd0, an_o},    32'hF);
        check({tag, "_frame"}, {31'd0, frame_o}, 32'h0);
    endtask

    // One clock: advance the timeline model at the rising edge, compare at the falling edge.
    task automatic step();
        int p, d, s;
        logic lz, dark_seg, dark_an;
        logic [6:0] exp_seg;
        logic exp_dp, exp_frame;
        logic [3:0] exp_an;
        @(posedge clk);
        p = k % FRAME;
        if (p == 0) begin
            for (int i = 0; i < DIGITS; i++) sh_nib[i] = int'(data[4*i +: 4]);
            sh_dp = dp;
            sh_blank = blank;
            sh_bright = int'(bright);
        end
        d = p / SLOT;
        s = p % SLOT;
        lz = 1'b0;
`ifdef SEG7_LZS_EN
        begin
            int msnz;
            msnz = 0;
            for (int i = 0; i < DIGITS; i++) if (sh_nib[i] != 0) msnz = i;
            lz = (d > msnz);
        end
`endif
        dark_seg  = sh_blank[d] || lz;
        dark_an   = sh_blank[d] || (lz && !sh_dp[d]);
        exp_seg   = dark_seg ? 7'h7F : font[sh_nib[d]];
        exp_dp    = (sh_dp[d] && !dark_an) ? 1'b0 : 1'b1;
        exp_an    = 4'hF;
        if (s >= BLANK && (k % 16) <= sh_bright && !dark_an) exp_an[d] = 1'b0;
        exp_frame = (p == 0);
        k++;
        @(negedge clk);
        check("seg",   {25'd0, seg_o},   {25'd0, exp_seg});
        check("dp",    {31'd0, dp_o},    {31'd0, exp_dp});
        check("an",    {28'd0, an_o},    {28'd0, exp_an});
        check("frame", {31'd0, frame_o}, {31'd0, exp_frame});
        if (s == 0) low_cnt = 0;
        if (an_o[d] == 1'b0) low_cnt++;
        if (s == SLOT - 1)
            check("an_low_per_slot", low_cnt, dark_an ? 0 : sh_bright + 1);
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    initial begin
        // Power-on reset: async assert, outputs dark before any clock edge.
        #1 rst_n = 1'b0;
        #1 check_reset_outputs("reset_async");
        data = 16'h1234; bright = 4'd15;
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("reset_held");
        rst_n = 1'b1;
        k = 0;

        // Full brightness digits 1,2,3,4 for two frames.
        run(2 * FRAME);

        // Mid-frame data change must wait for the next capture.
        run(30);
        data = 16'hFEDC;
        run(2 * FRAME - 30);

        // Blank digit 2, dp on digit 0.
        blank = 4'b0100; dp = 4'b0001;
        run(2 * FRAME);

        // Quarter-ish brightness.
        bright = 4'd3; blank = 4'b0000;
        run(2 * FRAME);

        // Random inputs changing at random points.
        repeat (25) begin
            run($urandom_range(5, 120));
            data   = 16'($urandom);
            dp     = 4'($urandom);
            blank  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            bright = 4'($urandom);
        end

        // Async reset mid-slot while an anode is lit.
        data = 16'h5A5A; blank = 4'h0; dp = 4'h0; bright = 4'd15;
        run(FRAME + 10 + ((FRAME - (k % FRAME)) % FRAME));
        while ((k % SLOT) != 11) step();
        check("pre_reset_an_lit", {31'd0, (an_o != 4'hF)}, 32'h1);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("reset_mid_slot");
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset_mid_held");
        rst_n = 1'b1;
        k = 0;
        run(FRAME);

        // Leading-zero cases; model follows the build's macro setting.
        data = 16'h0070; dp = 4'h0; blank = 4'h0; bright = 4'd15;
        run(2 * FRAME);
        dp = 4'b1000;
        run(2 * FRAME);
        data = 16'h0000; dp = 4'h0;
        run(2 * FRAME);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
